// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read-port arbiter.
// Build option: AXI_ARB_DEMAND_PRIORITY_EN (master 0 strict priority).
package axi_arb_pkg;

  localparam int unsigned MAX_MASTERS   = 8;
  localparam int unsigned MAX_IDX_W     = 3;
  localparam int unsigned DEF_ADDR_BITS = 16;
  localparam int unsigned DEF_LEN_W     = 8;
  localparam int unsigned DEF_TID_W     = 8;
  localparam int unsigned DEF_PREFIX_W  = 1;

  // Width of the master-index prefix carried in the AXI ID
  function automatic int unsigned prefix_w(input int unsigned n);
    return (n <= 2) ? 32'(1) : 32'($clog2(n));
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0]          addr;
    logic [DEF_LEN_W-1:0]              len;
    logic [DEF_PREFIX_W+DEF_TID_W-1:0] id;
  } ar_beat_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  // First set bit of mask at or after ptr, wrapping within n entries
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] mask,
                                       input logic [MAX_IDX_W-1:0]   ptr,
                                       input int unsigned            n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !r.found && mask[MAX_IDX_W'(j)]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin picker over the eligible-request mask.
// AXI_ARB_DEMAND_PRIORITY_EN: request 0 wins outright, others rotate.
module axi_rd_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned LOG_NUM_MASTERS = 1
) (
  input  logic [NUM_MASTERS-1:0]     i_req,
  input  logic [LOG_NUM_MASTERS-1:0] i_ptr,
  output logic                       o_found,
  output logic [LOG_NUM_MASTERS-1:0] o_idx
);

  logic [MAX_MASTERS-1:0] w_mask;
  rr_pick_t               w_pick;

  always_comb begin
    w_mask = MAX_MASTERS'(i_req);
    w_pick = '0;
`ifdef AXI_ARB_DEMAND_PRIORITY_EN
    if (w_mask[0]) begin
      w_pick.found = 1'b1;
      w_pick.idx   = '0;
    end else begin
      w_pick = rr_pick({w_mask[MAX_MASTERS-1:1], 1'b0}, MAX_IDX_W'(i_ptr), NUM_MASTERS);
    end
`else
    w_pick = rr_pick(w_mask, MAX_IDX_W'(i_ptr), NUM_MASTERS);
`endif
  end

  always_comb begin
    o_found = w_pick.found;
    o_idx   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      if (32'(w_pick.idx) == i) o_idx = LOG_NUM_MASTERS'(i);
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between NUM_MASTERS requesters with outstanding-burst limits.
// Build option: AXI_ARB_DEMAND_PRIORITY_EN (master 0 strict priority).
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned LOG_NUM_MASTERS = prefix_w(NUM_MASTERS),
  parameter int unsigned ADDR_BITS       = 16,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned OUTS_WIDTH      = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_MASTERS-1:0]                  s_ar_valid,
  output logic [NUM_MASTERS-1:0]                  s_ar_ready,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0]        s_ar_addr,
  input  logic [NUM_MASTERS*BURST_LEN_WIDTH-1:0]  s_ar_len,
  input  logic [NUM_MASTERS*TID_WIDTH-1:0]        s_ar_id,
  output logic                                    m_ar_valid,
  input  logic                                    m_ar_ready,
  output logic [ADDR_BITS-1:0]                    m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]              m_ar_len,
  output logic [LOG_NUM_MASTERS+TID_WIDTH-1:0]    m_ar_id,
  input  logic                                    m_r_valid,
  output logic                                    m_r_ready,
  input  logic                                    m_r_last,
  input  logic [DATA_WIDTH-1:0]                   m_r_data,
  input  logic [LOG_NUM_MASTERS+TID_WIDTH-1:0]    m_r_id,
  output logic [NUM_MASTERS-1:0]                  s_r_valid,
  input  logic [NUM_MASTERS-1:0]                  s_r_ready,
  output logic                                    s_r_last,
  output logic [DATA_WIDTH-1:0]                   s_r_data,
  output logic [TID_WIDTH-1:0]                    s_r_id,
  output logic [NUM_MASTERS*OUTS_WIDTH-1:0]       outstanding,
  output logic                                    errorCode
);

  localparam int unsigned ID_W = LOG_NUM_MASTERS + TID_WIDTH;
  localparam logic [OUTS_WIDTH-1:0] OUTS_LIMIT = '1;

  slot_state_t                r_state;
  logic [ADDR_BITS-1:0]       r_addr;
  logic [BURST_LEN_WIDTH-1:0] r_len;
  logic [ID_W-1:0]            r_id;
  logic [LOG_NUM_MASTERS-1:0] r_ptr;
  logic [OUTS_WIDTH-1:0]      r_outs [NUM_MASTERS];
  logic                       r_error;

  logic [NUM_MASTERS-1:0]     w_elig;
  logic                       w_found;
  logic [LOG_NUM_MASTERS-1:0] w_gnt;
  logic                       w_ar_fire;
  logic [LOG_NUM_MASTERS-1:0] w_ptr_next;
  logic [ADDR_BITS-1:0]       w_addr_sel;
  logic [BURST_LEN_WIDTH-1:0] w_len_sel;
  logic [TID_WIDTH-1:0]       w_id_sel;
  logic [LOG_NUM_MASTERS-1:0] w_sel;
  logic                       w_sel_ok;
  logic                       w_r_ready;
  logic [NUM_MASTERS-1:0]     w_dec;

  // Eligibility uses the registered count, ignoring a same-cycle decrement
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      w_elig[i] = s_ar_valid[i] && (r_outs[i] != OUTS_LIMIT);
  end

  axi_rd_arbiter_rr #(
    .NUM_MASTERS    (NUM_MASTERS),
    .LOG_NUM_MASTERS(LOG_NUM_MASTERS)
  ) u_rr (
    .i_req  (w_elig),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_idx  (w_gnt)
  );

  assign w_ar_fire = w_found && ((r_state == SLOT_EMPTY) || m_ar_ready) && !rst;

  always_comb begin
    s_ar_ready = '0;
    w_addr_sel = '0;
    w_len_sel  = '0;
    w_id_sel   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (32'(w_gnt) == i) begin
        s_ar_ready[i] = w_ar_fire;
        w_addr_sel    = s_ar_addr[i*ADDR_BITS +: ADDR_BITS];
        w_len_sel     = s_ar_len[i*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        w_id_sel      = s_ar_id[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_ar_fire) begin
      if (32'(w_gnt) == NUM_MASTERS - 1) w_ptr_next = '0;
      else                               w_ptr_next = w_gnt + 1'b1;
`ifdef AXI_ARB_DEMAND_PRIORITY_EN
      if (w_gnt == '0) w_ptr_next = r_ptr;
`endif
    end
  end

  assign w_sel = m_r_id[ID_W-1:TID_WIDTH];

  generate
    if (2**LOG_NUM_MASTERS <= NUM_MASTERS) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_range
      assign w_sel_ok = (32'(w_sel) < NUM_MASTERS);
    end
  endgenerate

  // Beats with an unknown prefix are accepted and dropped
  always_comb begin
    s_r_valid = '0;
    w_dec     = '0;
    w_r_ready = !w_sel_ok;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_sel_ok && 32'(w_sel) == i) begin
        s_r_valid[i] = m_r_valid;
        w_r_ready    = s_r_ready[i];
        w_dec[i]     = m_r_valid && s_r_ready[i] && m_r_last;
      end
    end
  end

  assign m_r_ready = w_r_ready;
  assign s_r_last  = m_r_last;
  assign s_r_data  = m_r_data;
  assign s_r_id    = m_r_id[TID_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_error <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) r_outs[i] <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      case (r_state)
        SLOT_EMPTY: if (w_ar_fire) r_state <= SLOT_FULL;
        SLOT_FULL:  if (m_ar_ready && !w_ar_fire) r_state <= SLOT_EMPTY;
        default:    r_state <= SLOT_EMPTY;
      endcase
      if (w_ar_fire) begin
        r_addr <= w_addr_sel;
        r_len  <= w_len_sel;
        r_id   <= {w_gnt, w_id_sel};
      end
      if (m_r_valid && !w_sel_ok) r_error <= 1'b1;
      // Simultaneous grant and burst completion leave the count unchanged
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        case ({s_ar_ready[i], w_dec[i]})
          2'b10:   r_outs[i] <= r_outs[i] + 1'b1;
          2'b01:   if (r_outs[i] != '0) r_outs[i] <= r_outs[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      outstanding[i*OUTS_WIDTH +: OUTS_WIDTH] = r_outs[i];
  end

  assign m_ar_valid = (r_state == SLOT_FULL);
  assign m_ar_addr  = r_addr;
  assign m_ar_len   = r_len;
  assign m_ar_id    = r_id;
  assign errorCode  = r_error;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: 2-master default instance plus a 3-master instance.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

`ifdef AXI_ARB_DEMAND_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk, rst;
  int   checks, errors;

  // two-master instance
  logic [1:0]  s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [15:0] s_ar_len, s_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [8:0]  m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data;
  logic [8:0]  m_r_id;
  logic [1:0]  s_r_valid, s_r_ready;
  logic        s_r_last;
  logic [7:0]  s_r_data, s_r_id;
  logic [5:0]  outstanding;
  logic        errorCode;

  // three-master instance
  logic [2:0]  s_ar_valid3, s_ar_ready3;
  logic [47:0] s_ar_addr3;
  logic [23:0] s_ar_len3, s_ar_id3;
  logic        m_ar_valid3, m_ar_ready3;
  logic [15:0] m_ar_addr3;
  logic [7:0]  m_ar_len3;
  logic [9:0]  m_ar_id3;
  logic        m_r_valid3, m_r_ready3, m_r_last3;
  logic [7:0]  m_r_data3;
  logic [9:0]  m_r_id3;
  logic [2:0]  s_r_valid3, s_r_ready3;
  logic        s_r_last3;
  logic [7:0]  s_r_data3, s_r_id3;
  logic [8:0]  outstanding3;
  logic        errorCode3;

  axi_rd_arbiter u_dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .s_r_data(s_r_data), .s_r_id(s_r_id),
    .outstanding(outstanding), .errorCode(errorCode)
  );

  axi_rd_arbiter #(.NUM_MASTERS(3), .LOG_NUM_MASTERS(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid3), .s_ar_ready(s_ar_ready3), .s_ar_addr(s_ar_addr3),
    .s_ar_len(s_ar_len3), .s_ar_id(s_ar_id3),
    .m_ar_valid(m_ar_valid3), .m_ar_ready(m_ar_ready3), .m_ar_addr(m_ar_addr3),
    .m_ar_len(m_ar_len3), .m_ar_id(m_ar_id3),
    .m_r_valid(m_r_valid3), .m_r_ready(m_r_ready3), .m_r_last(m_r_last3),
    .m_r_data(m_r_data3), .m_r_id(m_r_id3),
    .s_r_valid(s_r_valid3), .s_r_ready(s_r_ready3), .s_r_last(s_r_last3),
    .s_r_data(s_r_data3), .s_r_id(s_r_id3),
    .outstanding(outstanding3), .errorCode(errorCode3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  localparam ar_beat_t BEAT0 = '{addr: 16'h1000, len: 8'h00, id: 9'h011};
  localparam ar_beat_t BEAT1 = '{addr: 16'h2000, len: 8'h01, id: 9'h122};

  initial begin
    int       g;
    ar_beat_t exp_beat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    s_ar_valid = 2'b11; s_ar_addr = {16'h2000, 16'h1000};
    s_ar_len = {8'h01, 8'h00}; s_ar_id = {8'h22, 8'h11};
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = 2'b00;
    s_ar_valid3 = '0; s_ar_addr3 = {16'h3000, 16'h2000, 16'h1000};
    s_ar_len3 = '0; s_ar_id3 = {8'h30, 8'h20, 8'h10};
    m_ar_ready3 = 1'b0; m_r_valid3 = 1'b0; m_r_last3 = 1'b0; m_r_data3 = '0; m_r_id3 = '0;
    s_r_ready3 = '0;

    // reset state, requests held during reset
    tick(); tick();
    check("rst_ar_ready", 64'(s_ar_ready), 64'(2'b00));
    check("rst_m_ar_valid", 64'(m_ar_valid), 64'(1'b0));
    check("rst_outstanding", 64'(outstanding), 64'(6'h00));
    check("rst_error", 64'(errorCode), 64'(1'b0));

    // contested round-robin, drain+refill every cycle
    rst = 1'b0; m_ar_ready = 1'b1; #1;
    check("first_m_ar_valid_low", 64'(m_ar_valid), 64'(1'b0));
    for (int k = 0; k < 5; k++) begin
      g = PRIO ? 0 : (k % 2);
      check("alt_ar_ready", 64'(s_ar_ready), 64'(g == 1 ? 2'b10 : 2'b01));
      tick();
      check("alt_m_ar_valid", 64'(m_ar_valid), 64'(1'b1));
      exp_beat = (g == 1) ? BEAT1 : BEAT0;
      check("alt_ar_beat", 64'({m_ar_addr, m_ar_len, m_ar_id}), 64'(exp_beat));
    end
    check("alt_outstanding", 64'(outstanding), 64'(PRIO ? 6'h05 : 6'h13));

    // reset mid-burst
    rst = 1'b1; #1;
    check("rst_mid_ar_ready", 64'(s_ar_ready), 64'(2'b00));
    tick();
    check("rst_mid_m_ar_valid", 64'(m_ar_valid), 64'(1'b0));
    check("rst_mid_outstanding", 64'(outstanding), 64'(6'h00));
    rst = 1'b0; #1;
    check("rst_mid_ptr0", 64'(s_ar_ready), 64'(2'b01));

    // slot held while DRAM stalls
    s_ar_valid = 2'b01; s_ar_addr = {16'h2000, 16'h0EEF}; m_ar_ready = 1'b0; #1;
    check("stall_first_ready", 64'(s_ar_ready), 64'(2'b01));
    tick();
    s_ar_valid = 2'b11; #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_m_ar_valid", 64'(m_ar_valid), 64'(1'b1));
      check("stall_addr", 64'(m_ar_addr), 64'(16'h0EEF));
      check("stall_ar_ready", 64'(s_ar_ready), 64'(2'b00));
      tick();
    end
    m_ar_ready = 1'b1; #1;
    check("unstall_ar_ready", 64'(s_ar_ready), 64'(PRIO ? 2'b01 : 2'b10));
    tick();
    check("refill_addr", 64'(m_ar_addr), 64'(PRIO ? 16'h0EEF : 16'h2000));
    s_ar_valid = 2'b00;
    tick();
    check("drain_m_ar_valid", 64'(m_ar_valid), 64'(1'b0));
    s_ar_addr = {16'h2000, 16'h1000};
    do_reset();

    // grant and burst completion on the same master in one cycle
    s_ar_valid = 2'b10; #1;
    check("incdec_ar_ready0", 64'(s_ar_ready), 64'(2'b10));
    tick();
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 9'h122; s_r_ready = 2'b10; #1;
    check("incdec_ar_ready1", 64'(s_ar_ready), 64'(2'b10));
    check("incdec_r_ready", 64'(m_r_ready), 64'(1'b1));
    tick();
    s_ar_valid = 2'b00; m_r_valid = 1'b0; #1;
    check("incdec_outstanding", 64'(outstanding), 64'(6'h08));
    do_reset();

    // outstanding limit on master 1
    s_ar_valid = 2'b10; #1;
    for (int k = 0; k < 7; k++) begin
      check("limit_ar_ready", 64'(s_ar_ready), 64'(2'b10));
      tick();
    end
    check("limit_outstanding", 64'(outstanding), 64'(6'h38));
    check("limit_blocked", 64'(s_ar_ready), 64'(2'b00));
    s_ar_valid = 2'b11; #1;
    check("limit_m0_granted", 64'(s_ar_ready), 64'(2'b01));
    tick();
    s_ar_valid = 2'b10;
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 9'h133; s_r_ready = 2'b10; #1;
    check("limit_registered_count", 64'(s_ar_ready), 64'(2'b00));
    check("limit_r_valid", 64'(s_r_valid), 64'(2'b10));
    tick();
    m_r_valid = 1'b0; #1;
    check("limit_after_dec", 64'(outstanding), 64'(6'h31));
    check("limit_regrant", 64'(s_ar_ready), 64'(2'b10));
    tick();
    check("limit_regrant_id", 64'(m_ar_id), 64'(9'h122));
    s_ar_valid = 2'b00;
    do_reset();

    // R burst of 4 beats to master 1 with one stall
    m_r_valid = 1'b1; m_r_id = 9'h105; s_r_ready = 2'b10;
    for (int b = 0; b < 4; b++) begin
      m_r_data = 8'hA0 + 8'(b);
      m_r_last = (b == 3);
      if (b == 2) begin
        s_r_ready = 2'b00; #1;
        check("burst_stall_r_ready", 64'(m_r_ready), 64'(1'b0));
        check("burst_stall_r_valid", 64'(s_r_valid), 64'(2'b10));
        tick();
        s_r_ready = 2'b10;
      end
      #1;
      check("burst_r_valid", 64'(s_r_valid), 64'(2'b10));
      check("burst_r_id", 64'(s_r_id), 64'(8'h05));
      check("burst_r_data", 64'(s_r_data), 64'(8'hA0 + 8'(b)));
      check("burst_r_last", 64'(s_r_last), 64'(b == 3));
      check("burst_r_ready", 64'(m_r_ready), 64'(1'b1));
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0; #1;
    check("burst_underflow", 64'(outstanding), 64'(6'h00));
    check("burst_no_error", 64'(errorCode), 64'(1'b0));
    m_r_valid = 1'b1; m_r_id = 9'h0AA; #1;
    check("route_m0_valid", 64'(s_r_valid), 64'(2'b01));
    check("route_m0_wrong_ready", 64'(m_r_ready), 64'(1'b0));
    s_r_ready = 2'b11; #1;
    check("route_m0_ready", 64'(m_r_ready), 64'(1'b1));
    m_r_valid = 1'b0;

    // three masters: contested grants
    s_ar_valid3 = 3'b111; m_ar_ready3 = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      g = PRIO ? 0 : k;
      check("m3_ar_ready", 64'(s_ar_ready3), 64'(3'b001 << g));
      tick();
      check("m3_ar_id", 64'(m_ar_id3), 64'({2'(g), 8'(8'h10 + 8'(16 * g))}));
    end
    s_ar_valid3 = 3'b000;

    // three masters: invalid prefix is dropped and flagged
    m_r_valid3 = 1'b1; m_r_id3 = {2'd3, 8'h44}; s_r_ready3 = 3'b000; #1;
    check("bad_prefix_r_ready", 64'(m_r_ready3), 64'(1'b1));
    check("bad_prefix_r_valid", 64'(s_r_valid3), 64'(3'b000));
    check("bad_prefix_err_pre", 64'(errorCode3), 64'(1'b0));
    tick();
    m_r_valid3 = 1'b0; #1;
    check("bad_prefix_err_set", 64'(errorCode3), 64'(1'b1));
    tick(); tick();
    check("bad_prefix_err_hold", 64'(errorCode3), 64'(1'b1));
    m_r_valid3 = 1'b1; m_r_id3 = {2'd2, 8'h44}; #1;
    check("m3_route_2", 64'(s_r_valid3), 64'(3'b100));
    m_r_valid3 = 1'b0;
    do_reset();
    check("bad_prefix_err_clear", 64'(errorCode3), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
